program_sequencer: RTL and testbench
====================================

# program_sequencer

Instruction sequencer that drives the control side of the `datapath` block. It fetches 24-bit instruction words from a synchronous program memory, decodes them into the datapath control/address/immediate signals, and steps the program counter. It also closes the halt loop: it issues `haltCondition` and stops on the datapath's `halt` response. It sits between program ROM and `datapath` as the project-1 top-level controller.

## Interface
- `PC_WIDTH`, 8, program-counter and memory-address width; legal range 1..8.
- `clk` in 1: system clock; all state changes on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: launches a program from pc=0; honoured only in IDLE or HALTED.
- `imem_addr` out PC_WIDTH: program memory address.
- `imem_en` out 1: memory read enable.
- `imem_data` in 24: instruction word, valid the cycle after `imem_en`.
- `halt` in 1: datapath halt flag, registered inside datapath.
- `writeEnable`, `writeSourceSelect`, `muxASelect`, `muxBSelect` out 1 each: datapath controls.
- `extInputData` out 8: immediate / jump-field bus.
- `destAddress`, `aAddress`, `bAddress`, `aluOpCode` out 4 each: datapath fields.
- `haltCondition` out 1: requests the datapath zero-test of register `aAddress`.
- `busy` out 1: high in every state except IDLE and HALTED.
- `done` out 1: high in HALTED.
- `illegal` out 1: sticky; set by an undefined class; cleared by `rst` or an accepted `start`.
- `instr_count` out 16: retired-instruction counter.

## Operation
- Reset: state=IDLE, pc=0, IR=0, `instr_count`=0, `illegal`=0. All outputs are 0.
- Instruction fields: class=[23:20], op=[19:16], d=[15:12], a=[11:8], b=[7:4], imm=[7:0].
- The field outputs always reflect IR: `aluOpCode`=op, `destAddress`=d, `aAddress`=a, `bAddress`=b, `extInputData`=imm.
- `writeEnable` and `haltCondition` are asserted only in EXECUTE.
- The select outputs are decoded from IR in every state.
- Class 0x0, ALU reg-reg: we=1, src=0, muxA=0, muxB=0.
- Class 0x1, ALU reg-imm: we=1, src=0, muxA=0, muxB=1.
- Class 0x2, LOADI: we=1, src=1; d ← imm.
- Class 0x3, JMP: we=0; next pc = imm[PC_WIDTH-1:0].
- Class 0x4, HALTZ: we=0, `haltCondition`=1.
- Class 0xF, NOP: no effect.
- Any other class: executes as NOP and sets `illegal`.
- FSM states: IDLE, FETCH, DECODE, EXECUTE, HALT_WAIT, HALTED.
  - IDLE → FETCH on `start`.
  - FETCH: `imem_addr`=pc, `imem_en`=1; → DECODE.
  - DECODE: IR ← `imem_data`; → EXECUTE.
  - EXECUTE: controls are driven and the instruction retires (`instr_count`+1, saturating at 0xFFFF). HALTZ → HALT_WAIT. JMP → FETCH with pc=target. All others → FETCH with pc=pc+1.
  - HALT_WAIT: samples `halt`. If 1 → HALTED with pc unchanged. If 0 → FETCH with pc+1.
  - HALTED → FETCH on `start`.
- An accepted `start` sets pc=0, clears `instr_count` and `illegal`, and re-zeroes IR.
- `start` in any other state is ignored.
- pc increments wrap modulo 2^PC_WIDTH; no error is raised.

## Timing
- Non-HALTZ instruction: 3 cycles (FETCH, DECODE, EXECUTE). HALTZ: 4 cycles.
- The register-file write commits on the rising edge that ends EXECUTE. Dependent reads in the next instruction see the new value.
- `imem_data` must be valid one cycle after `imem_en` (synchronous ROM). It is ignored in every other cycle.
- `halt` is registered by the datapath on the edge ending EXECUTE and is sampled in HALT_WAIT.
- HALTED is entered on the edge ending HALT_WAIT. `done` rises in the next cycle.
- `rst` overrides `start` and all FSM activity on the same edge, including mid-instruction. A write pending in EXECUTE with `rst` high is still presented to the datapath, whose own reset dominates.
- `instr_count` saturates at 0xFFFF. At that value a further retire leaves it unchanged.

## Test plan
- **Reset then start.** Reset held 2 cycles, then `start` pulse → outputs all 0 during reset. `imem_addr`=0 with `imem_en`=1 one cycle after `start`. `busy`=1.
- **LOADI then ALU.** Program `LOADI R1,0x05`; `ALU-imm op=ADD R15=R1+0x03`; `HALTZ R0` → `writeSourceSelect`=1 in EXECUTE of the first instruction. `R15_out`=0x08 after the second. `done`=1 after 10 cycles. `instr_count`=3.
- **HALTZ on non-zero register.** HALTZ where the register holds 0x01 → FETCH resumes at pc+1. `done` stays 0.
- **JMP wrap.** With PC_WIDTH=4, `JMP 0x1F` → next `imem_addr`=0xF. A NOP at 0xF → next `imem_addr`=0x0.
- **Illegal class.** Class 0x7 → no `writeEnable` pulse. `illegal`=1 and held. An accepted `start` clears it.
- **Reset mid-EXECUTE and ignored start.** `rst` asserted in EXECUTE → IDLE next cycle, pc=0. `start` asserted during DECODE → ignored, pc unchanged.

Source files
------------

// File: rtl/program_sequencer.sv
// program_sequencer
//   Control-side sequencer for the project-1 datapath. Fetches 24-bit words
//   from a synchronous program ROM, holds them in an instruction register,
//   decodes them into datapath controls and steps the program counter. HALTZ
//   instructions request a zero test from the datapath and stop the machine
//   when the datapath answers with halt.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   start              launch program at pc=0 (accepted in IDLE / HALTED only)
//   imem_addr/en/data  program ROM address, read enable, word (1-cycle latency)
//   halt               registered zero-test result from the datapath
//   writeEnable, writeSourceSelect, muxASelect, muxBSelect
//                      datapath control strobes / selects
//   extInputData       immediate / jump-target field (IR[7:0])
//   destAddress, aAddress, bAddress, aluOpCode
//                      register and ALU fields taken from IR
//   haltCondition      request zero test of register aAddress
//   busy, done         running / halted status
//   illegal            sticky undefined-class flag
//   instr_count        saturating retired-instruction counter
module program_sequencer #(
    parameter int unsigned PC_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic [PC_WIDTH-1:0] imem_addr,
    output logic                imem_en,
    input  logic [23:0]         imem_data,
    input  logic                halt,
    output logic                writeEnable,
    output logic                writeSourceSelect,
    output logic                muxASelect,
    output logic                muxBSelect,
    output logic [7:0]          extInputData,
    output logic [3:0]          destAddress,
    output logic [3:0]          aAddress,
    output logic [3:0]          bAddress,
    output logic [3:0]          aluOpCode,
    output logic                haltCondition,
    output logic                busy,
    output logic                done,
    output logic                illegal,
    output logic [15:0]         instr_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_HALT_WAIT,
        S_HALTED
    } state_t;

    typedef enum logic [3:0] {
        CLS_ALU_RR = 4'h0,
        CLS_ALU_RI = 4'h1,
        CLS_LOADI  = 4'h2,
        CLS_JMP    = 4'h3,
        CLS_HALTZ  = 4'h4,
        CLS_NOP    = 4'hF
    } cls_t;

    localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

    state_t              state;
    state_t              state_next;
    logic [PC_WIDTH-1:0] pc;
    logic [23:0]         ir;
    cls_t                cls;
    logic                cls_known;
    logic                start_ok;

    assign cls       = cls_t'(ir[23:20]);
    assign cls_known = (cls inside {CLS_ALU_RR, CLS_ALU_RI, CLS_LOADI,
                                    CLS_JMP, CLS_HALTZ, CLS_NOP});
    assign start_ok  = start && (state inside {S_IDLE, S_HALTED});

    // Field outputs and selects follow IR in every state
    assign aluOpCode         = ir[19:16];
    assign destAddress       = ir[15:12];
    assign aAddress          = ir[11:8];
    assign bAddress          = ir[7:4];
    assign extInputData      = ir[7:0];
    assign writeSourceSelect = (cls == CLS_LOADI);
    assign muxASelect        = 1'b0;
    assign muxBSelect        = (cls == CLS_ALU_RI);

    assign busy = !(state inside {S_IDLE, S_HALTED});
    assign done = (state == S_HALTED);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        imem_en       = 1'b0;
        imem_addr     = '0;
        writeEnable   = 1'b0;
        haltCondition = 1'b0;
        case (state)
            S_IDLE, S_HALTED: begin
                if (start) state_next = S_FETCH;
            end
            S_FETCH: begin
                imem_en    = 1'b1;
                imem_addr  = pc;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                state_next = S_EXECUTE;
            end
            S_EXECUTE: begin
                writeEnable   = (cls inside {CLS_ALU_RR, CLS_ALU_RI, CLS_LOADI});
                haltCondition = (cls == CLS_HALTZ);
                state_next    = (cls == CLS_HALTZ) ? S_HALT_WAIT : S_FETCH;
            end
            S_HALT_WAIT: begin
                state_next = halt ? S_HALTED : S_FETCH;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Program counter, instruction register, retire counter, illegal flag.
    // HALTZ defers its pc step to HALT_WAIT, where the halt answer is known.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= '0;
            ir          <= '0;
            instr_count <= '0;
            illegal     <= 1'b0;
        end else begin
            if (start_ok) begin
                pc          <= '0;
                ir          <= '0;
                instr_count <= '0;
                illegal     <= 1'b0;
            end
            case (state)
                S_DECODE: ir <= imem_data;
                S_EXECUTE: begin
                    if (instr_count != '1) instr_count <= instr_count + 16'd1;
                    if (!cls_known) illegal <= 1'b1;
                    if (cls == CLS_JMP) begin
                        pc <= ir[PC_WIDTH-1:0];
                    end else if (cls != CLS_HALTZ) begin
                        pc <= pc + PC_ONE;
                    end
                end
                S_HALT_WAIT: begin
                    if (!halt) pc <= pc + PC_ONE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_program_sequencer.sv
// Testbench for program_sequencer: a ROM and a minimal datapath (register
// file + ALU + registered zero test) form the environment; an instruction-
// level ISA model predicts pc flow, register contents, counters and flags.
module tb_program_sequencer;

    localparam int unsigned PW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [PW-1:0] imem_addr;
    logic          imem_en;
    logic [23:0]   imem_data;
    logic          halt;
    logic          writeEnable, writeSourceSelect, muxASelect, muxBSelect;
    logic [7:0]    extInputData;
    logic [3:0]    destAddress, aAddress, bAddress, aluOpCode;
    logic          haltCondition, busy, done, illegal;
    logic [15:0]   instr_count;

    always #5 clk = ~clk;

    program_sequencer #(.PC_WIDTH(PW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .imem_addr(imem_addr), .imem_en(imem_en), .imem_data(imem_data),
        .halt(halt),
        .writeEnable(writeEnable), .writeSourceSelect(writeSourceSelect),
        .muxASelect(muxASelect), .muxBSelect(muxBSelect),
        .extInputData(extInputData), .destAddress(destAddress),
        .aAddress(aAddress), .bAddress(bAddress), .aluOpCode(aluOpCode),
        .haltCondition(haltCondition), .busy(busy), .done(done),
        .illegal(illegal), .instr_count(instr_count)
    );

    logic [23:0] rom     [16];
    logic [7:0]  dp_regs [16];

    function automatic logic [7:0] alu(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y);
        case (op)
            4'h0:    return x + y;
            4'h1:    return x - y;
            4'h2:    return x & y;
            4'h3:    return x | y;
            default: return x ^ y;
        endcase
    endfunction

    // Environment: synchronous ROM (garbage when not enabled) and datapath
    always @(posedge clk) begin
        if (imem_en) imem_data <= rom[imem_addr];
        else         imem_data <= 24'($urandom);
        if (rst) begin
            halt <= 1'b0;
            for (int i = 0; i < 16; i++) dp_regs[i] <= '0;
        end else begin
            halt <= haltCondition && (dp_regs[aAddress] == 8'd0);
            if (writeEnable)
                dp_regs[destAddress] <= writeSourceSelect ? extInputData :
                    alu(aluOpCode, dp_regs[aAddress], muxBSelect ? extInputData : dp_regs[bAddress]);
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0]  m_pc;
    logic [15:0] m_count;
    logic        m_illegal;
    logic [7:0]  m_regs [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = '0; m_count = '0; m_illegal = 1'b0;
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
    endtask

    // ISA-level effect of one instruction
    task automatic model_exec(input logic [23:0] w, output bit halted);
        logic [3:0] c, op, d, a, b;
        logic [7:0] imm;
        c = w[23:20]; op = w[19:16]; d = w[15:12]; a = w[11:8]; b = w[7:4]; imm = w[7:0];
        halted = 1'b0;
        case (c)
            4'h0: begin m_regs[d] = alu(op, m_regs[a], m_regs[b]); m_pc = m_pc + 4'd1; end
            4'h1: begin m_regs[d] = alu(op, m_regs[a], imm);       m_pc = m_pc + 4'd1; end
            4'h2: begin m_regs[d] = imm;                           m_pc = m_pc + 4'd1; end
            4'h3: m_pc = imm[3:0];
            4'h4: if (m_regs[a] == 8'd0) halted = 1'b1; else m_pc = m_pc + 4'd1;
            4'hF: m_pc = m_pc + 4'd1;
            default: begin m_illegal = 1'b1; m_pc = m_pc + 4'd1; end
        endcase
        if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_busy", 32'(busy), 0);            chk("rst_done", 32'(done), 0);
        chk("rst_imem_en", 32'(imem_en), 0);      chk("rst_imem_addr", 32'(imem_addr), 0);
        chk("rst_we", 32'(writeEnable), 0);       chk("rst_hc", 32'(haltCondition), 0);
        chk("rst_wss", 32'(writeSourceSelect), 0); chk("rst_muxb", 32'(muxBSelect), 0);
        chk("rst_muxa", 32'(muxASelect), 0);      chk("rst_ext", 32'(extInputData), 0);
        chk("rst_fields", 32'({destAddress, aAddress, bAddress, aluOpCode}), 0);
        chk("rst_illegal", 32'(illegal), 0);      chk("rst_count", 32'(instr_count), 0);
    endtask

    task automatic apply_reset(input int cycles);
        rst = 1'b1; start = 1'b0;
        repeat (cycles) begin
            @(negedge clk);
            chk_reset_outputs();
        end
        rst = 1'b0;
        model_reset();
    endtask

    // Pulse start; returns at the negedge of the first FETCH
    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        m_pc = '0; m_count = '0; m_illegal = 1'b0;
        chk("start_imem_en", 32'(imem_en), 1);  chk("start_imem_addr", 32'(imem_addr), 0);
        chk("start_busy", 32'(busy), 1);        chk("start_done", 32'(done), 0);
        chk("start_illegal", 32'(illegal), 0);  chk("start_count", 32'(instr_count), 0);
        chk("start_ir_zero", 32'({aluOpCode, extInputData}), 0);
    endtask

    // One instruction, entered and left at a FETCH (or HALTED) negedge
    task automatic run_instr(output bit halted);
        logic [23:0] w;
        logic [3:0]  c;
        chk("fetch_en", 32'(imem_en), 1);
        chk("fetch_addr", 32'(imem_addr), 32'(m_pc));
        w = rom[m_pc]; c = w[23:20];
        @(negedge clk);
        chk("decode_en", 32'(imem_en), 0);
        chk("decode_we", 32'(writeEnable), 0);
        @(negedge clk);
        chk("exec_we", 32'(writeEnable), 32'(c <= 4'h2));
        chk("exec_hc", 32'(haltCondition), 32'(c == 4'h4));
        chk("exec_wss", 32'(writeSourceSelect), 32'(c == 4'h2));
        chk("exec_muxb", 32'(muxBSelect), 32'(c == 4'h1));
        chk("exec_muxa", 32'(muxASelect), 0);
        chk("exec_fields", 32'({aluOpCode, destAddress, aAddress, extInputData}),
            32'({w[19:16], w[15:12], w[11:8], w[7:0]}));
        chk("exec_b", 32'(bAddress), 32'(w[7:4]));
        chk("exec_en", 32'(imem_en), 0);
        model_exec(w, halted);
        @(negedge clk);
        if (c == 4'h4) begin
            chk("hwait_busy", 32'(busy), 1);
            chk("hwait_hc", 32'(haltCondition), 0);
            @(negedge clk);
        end
        chk("post_done", 32'(done), 32'(halted));
        chk("post_busy", 32'(busy), 32'(!halted));
        chk("post_count", 32'(instr_count), 32'(m_count));
        chk("post_illegal", 32'(illegal), 32'(m_illegal));
        chk("post_reg", 32'(dp_regs[w[15:12]]), 32'(m_regs[w[15:12]]));
    endtask

    function automatic logic [23:0] rand_word();
        logic [3:0] tbl [8];
        logic [3:0] c;
        tbl = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'hF, 4'h7, 4'hA};
        c = tbl[$urandom_range(7)];
        return {c, 4'($urandom_range(3)), 16'($urandom)};
    endfunction

    initial begin
        bit h;
        bit last_halted;

        // LOADI R1,5 ; ADD R15=R1+3 ; HALTZ R0
        for (int i = 0; i < 16; i++) rom[i] = 24'hF00000;
        rom[0] = 24'h201005; rom[1] = 24'h10F103; rom[2] = 24'h400000;
        apply_reset(2);
        do_start();
        for (int i = 0; i < 3; i++) run_instr(h);
        chk("prog1_r15", 32'(dp_regs[15]), 32'h08);
        chk("prog1_done", 32'(done), 1);
        chk("prog1_count", 32'(instr_count), 3);

        // HALTZ on non-zero register resumes at pc+1
        rom[0] = 24'h202001; rom[1] = 24'h400200; rom[2] = 24'h400000;
        do_start();
        run_instr(h);
        run_instr(h);
        chk("haltz_nz_done", 32'(done), 0);
        chk("haltz_nz_addr", 32'(imem_addr), 2);
        run_instr(h);
        chk("haltz_z_done", 32'(done), 1);

        // JMP 0x1F wraps to 0xF; NOP at 0xF wraps pc to 0
        for (int i = 0; i < 16; i++) rom[i] = 24'hF00000;
        rom[0] = 24'h30001F;
        do_start();
        run_instr(h);
        chk("jmp_target", 32'(imem_addr), 32'hF);
        run_instr(h);
        chk("pc_wrap", 32'(imem_addr), 0);
        run_instr(h);

        // Illegal class: no write, sticky flag, cleared by accepted start
        apply_reset(1);
        rom[0] = 24'h712345; rom[1] = 24'hF00000; rom[2] = 24'h400000;
        do_start();
        run_instr(h);
        chk("illegal_set", 32'(illegal), 1);
        run_instr(h);
        run_instr(h);
        chk("illegal_held", 32'(illegal), 1);
        chk("illegal_halted", 32'(done), 1);
        rom[0] = 24'hF00000; rom[1] = 24'h204077; rom[2] = 24'h205055;
        do_start();

        // start in DECODE ignored, then reset during EXECUTE
        run_instr(h);
        chk("ign_fetch_addr", 32'(imem_addr), 1);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ign_exec_we", 32'(writeEnable), 1);
        chk("ign_exec_dest", 32'(destAddress), 4);
        model_exec(rom[1], h);
        @(negedge clk);
        chk("ign_pc_kept", 32'(imem_addr), 2);
        chk("ign_count", 32'(instr_count), 2);
        @(negedge clk);
        @(negedge clk);
        chk("mid_exec_we", 32'(writeEnable), 1);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs();
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk("idle_after_rst_busy", 32'(busy), 0);
        chk("idle_after_rst_en", 32'(imem_en), 0);
        do_start();
        run_instr(h);

        // Randomized programs against the ISA model
        last_halted = 1'b0;
        for (int it = 0; it < 12; it++) begin
            for (int i = 0; i < 16; i++) rom[i] = rand_word();
            if ((it % 2 == 0) || !last_halted) apply_reset(1);
            do_start();
            h = 1'b0;
            for (int k = 0; k < 20 && !h; k++) run_instr(h);
            last_halted = h;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
